// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and defaults for the ddr port arbiter
package ddr_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;
  localparam int TIMEOUT_DEF = 32;
  localparam int CNT_W = 8;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker favouring the port not served last
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       last,
  input  logic       update,
  output logic [1:0] gnt
);
  logic last_q, last_d;
  always_comb begin
    last_d = update ? last : last_q;
    gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
  end
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin two-port sequencer for ddr_sim port A
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              ack_0,
  output logic              err_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              ack_1,
  output logic              err_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_rdy_we,
  input  logic              mem_rdy_re
);
  state_t state_q, state_d;
  logic sel_q, sel_d, we_q, we_d, err_q, err_d, done;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] gnt;
  rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({req_1, req_0}),
    .last(sel_q),
    .update(state_q == DONE),
    .gnt(gnt)
  );
  assign done = we_q ? mem_rdy_we : mem_rdy_re;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    err_d = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (req_0 || req_1) begin
        state_d = ISSUE;
        sel_d = gnt[1];
        we_d = gnt[1] ? we_1 : we_0;
        addr_d = gnt[1] ? addr_1 : addr_0;
        wdata_d = gnt[1] ? wdata_1 : wdata_0;
        err_d = 1'b0;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: if (done) begin
        state_d = DONE;
        rdata0_d = (!we_q && !sel_q) ? mem_q : rdata0_q;
        rdata1_d = (!we_q && sel_q) ? mem_q : rdata1_q;
      end else if (cnt_q == CNT_W'(TIMEOUT)) begin
        state_d = DONE;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we = (state_q == ISSUE) && we_q;
  assign ack_0 = (state_q == DONE) && !sel_q;
  assign ack_1 = (state_q == DONE) && sel_q;
  assign err_0 = ack_0 && err_q;
  assign err_1 = ack_1 && err_q;
  assign rdata_0 = rdata0_q;
  assign rdata_1 = rdata1_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed self-checking bench for ddr_port_arbiter
module tb_ddr_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req_0 = 0, we_0 = 0, req_1 = 0, we_1 = 0;
  logic [18:0] addr_0 = '0, addr_1 = '0;
  logic [7:0] wdata_0 = '0, wdata_1 = '0;
  logic ack_0, err_0, ack_1, err_1, mem_we;
  logic [7:0] rdata_0, rdata_1, mem_wdata;
  logic [18:0] mem_addr;
  logic [7:0] mem_q = '0;
  logic mem_rdy_we = 0, mem_rdy_re = 0;
  int total = 0, bad = 0;
  int n, wc;
  logic e, stable;
  always #5 clk = ~clk;
  ddr_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .ack_0(ack_0), .err_0(err_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .ack_1(ack_1), .err_1(err_1), .rdata_1(rdata_1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_q(mem_q), .mem_rdy_we(mem_rdy_we), .mem_rdy_re(mem_rdy_re)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input int p, input logic w, input logic [18:0] a, input logic [7:0] wd,
                     input logic [7:0] q, input int d, output int cnt, output logic er,
                     output int wcnt, output logic stab);
    if (p == 0) begin req_0 = 1; we_0 = w; addr_0 = a; wdata_0 = wd; end
    else begin req_1 = 1; we_1 = w; addr_1 = a; wdata_1 = wd; end
    cnt = 0; er = 0; wcnt = 0; stab = 1;
    while (cnt < 60) begin
      tick;
      cnt++;
      mem_rdy_we = 0;
      mem_rdy_re = 0;
      if (mem_we) wcnt++;
      if (mem_addr !== a) stab = 0;
      if (p == 0 ? ack_0 : ack_1) begin
        er = p == 0 ? err_0 : err_1;
        break;
      end
      mem_q = q;
      if (cnt == 1 + d) begin
        if (w) mem_rdy_we = 1;
        else mem_rdy_re = 1;
      end
    end
    req_0 = 0;
    req_1 = 0;
    tick;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_ack", {ack_0, ack_1, err_0, err_1}, 0);
    chk("rst_rdata", {rdata_0, rdata_1}, 0);
    rst = 0;
    tick;
    txn(0, 1, 19'h00100, 8'hA5, 8'h00, 8, n, e, wc, stable);
    chk("t1_ack_cycle", n, 10);
    chk("t1_we_pulses", wc, 1);
    chk("t1_err", e, 0);
    chk("t1_addr_stable", stable, 1);
    chk("t1_wdata", mem_wdata, 8'hA5);
    chk("t1_ack_clear", ack_0, 0);
    req_1 = 1; we_1 = 0; addr_1 = 19'h00100;
    tick;
    chk("t2_issue_addr", mem_addr, 19'h00100);
    chk("t2_issue_we", mem_we, 0);
    mem_rdy_re = 1; mem_q = 8'h3C;
    tick;
    mem_rdy_re = 0; mem_rdy_we = 1;
    tick;
    chk("t2_no_early_ack", ack_1, 0);
    mem_rdy_we = 0; mem_rdy_re = 1; mem_q = 8'hA5;
    tick;
    chk("t2_ack", ack_1, 1);
    chk("t2_rdata", rdata_1, 8'hA5);
    chk("t2_err", err_1, 0);
    chk("t2_addr_done", mem_addr, 19'h00100);
    chk("t2_ack0", ack_0, 0);
    req_1 = 0; mem_rdy_re = 0; mem_q = 8'h00;
    tick;
    chk("t2_ack_clear", ack_1, 0);
    chk("t2_rdata_hold", rdata_1, 8'hA5);
    rst = 1;
    tick;
    rst = 0;
    req_0 = 1; we_0 = 0; addr_0 = 19'h00010;
    req_1 = 1; we_1 = 0; addr_1 = 19'h00020;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("t3_addr%0d", k), mem_addr, (k % 2) ? 19'h00020 : 19'h00010);
      tick;
      mem_rdy_re = 1; mem_q = 8'h50 + 8'(k);
      tick;
      mem_rdy_re = 0;
      chk($sformatf("t3_ack%0d", k), {ack_1, ack_0}, (k % 2) ? 2'b10 : 2'b01);
      chk($sformatf("t3_rdata%0d", k), (k % 2) ? rdata_1 : rdata_0, 8'h50 + k);
      tick;
    end
    req_0 = 0; req_1 = 0;
    tick;
    txn(0, 0, 19'h00200, 8'h00, 8'h11, 1, n, e, wc, stable);
    chk("t4_first_rdata", rdata_0, 8'h11);
    txn(0, 0, 19'h00201, 8'h00, 8'h22, 1, n, e, wc, stable);
    chk("t4_latency", n, 3);
    chk("t4_rdata", rdata_0, 8'h22);
    chk("t4_err", e, 0);
    txn(0, 0, 19'h00300, 8'h00, 8'h77, 1, n, e, wc, stable);
    chk("t5_first_rdata", rdata_0, 8'h77);
    txn(0, 0, 19'h00300, 8'h00, 8'hEE, -1, n, e, wc, stable);
    chk("t5_timeout_cycle", n, 35);
    chk("t5_err", e, 1);
    chk("t5_rdata_kept", rdata_0, 8'h77);
    chk("t5_addr_stable", stable, 1);
    req_1 = 1; we_1 = 1; addr_1 = 19'h00400; wdata_1 = 8'h99;
    tick;
    chk("t6_issue_we", mem_we, 1);
    tick;
    tick;
    rst = 1;
    tick;
    rst = 0; req_1 = 0;
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_wdata", mem_wdata, 0);
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_ack", {ack_0, ack_1, err_0, err_1}, 0);
    chk("t6_rst_rdata", {rdata_0, rdata_1}, 0);
    tick;
    tick;
    chk("t6_no_ack", {ack_0, ack_1, mem_we}, 0);
    txn(1, 1, 19'h00400, 8'h99, 8'h00, 1, n, e, wc, stable);
    chk("t6_after_cycle", n, 3);
    chk("t6_after_we", wc, 1);
    chk("t6_after_err", e, 0);
    chk("t6_after_wdata", mem_wdata, 8'h99);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Two-requester arbiter and sequencer for port A of the `ddr_sim` memory model (19-bit byte address, 8-bit data, `d_ready_we` / `d_ready_re` completion pulses). It grants one requester at a time in round-robin order and drives the memory with a single-cycle write strobe. It holds the address stable until the matching ready pulse arrives, then returns read data with a one-cycle acknowledge. It sits between the processor core (requester 0) and the image loader/DMA (requester 1). It replaces direct wiring of either agent to the memory.

## Interface
- `ADDR_W`, 19, byte address width
- `DATA_W`, 8, data width
- `TIMEOUT`, 32, cycles waited for a ready pulse before aborting (range 8..255)

Ports (`n` = 0, 1 for each requester port):
- `clk` in 1 — single clock for the block and the memory
- `rst` in 1 — synchronous, active-high reset
- `req_n` in 1 — request; held with address/data/direction until `ack_n`
- `we_n` in 1 — 1 = write, 0 = read
- `addr_n` in ADDR_W — byte address
- `wdata_n` in DATA_W — write data
- `ack_n` out 1 — one-cycle completion pulse
- `err_n` out 1 — pulses with `ack_n` when the transaction timed out
- `rdata_n` out DATA_W — read data, valid while `ack_n` = 1 and held until the next ack to that port
- `mem_addr` out ADDR_W — to `addr_a`
- `mem_wdata` out DATA_W — to `data_a`
- `mem_we` out 1 — to `we_a`
- `mem_q` in DATA_W — from `q_a`
- `mem_rdy_we` in 1 — from `d_ready_we`
- `mem_rdy_re` in 1 — from `d_ready_re`

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any `req_n` is high, the round-robin picker chooses the port not served last. The pointer resets to favour port 0.
  - The chosen port's addr/wdata/we are latched, and the FSM moves to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `mem_addr` and `mem_wdata` are driven from the latch.
  - `mem_we` = latched `we` for this cycle only.
  - Timeout counter cleared. Next state: WAIT.
- **WAIT**
  - Write: completes on `mem_rdy_we`. Read: completes on `mem_rdy_re`. A ready of the wrong kind is ignored.
  - On a read completion, `mem_q` is captured into the granted port's `rdata` in that same cycle.
  - The counter increments each cycle. When it reaches `TIMEOUT`, the FSM goes to DONE with an error flag set. A timed-out read leaves `rdata` unchanged.
- **DONE** (1 cycle)
  - `ack` (and `err` if flagged) is asserted to the granted port, the round-robin pointer is updated, and the FSM returns to IDLE.
- `mem_addr` and `mem_wdata` keep their last driven value in IDLE, DONE and WAIT. The memory treats any address change as a new access, so the address must never toggle spuriously.
- `mem_we` = 0 in every state except ISSUE.
- A requester that keeps `req` high after `ack` is treated as issuing a new transaction. If the other port is also requesting, the other port is served first.
- Requests arriving outside IDLE wait; they are never dropped.
- A read to the same address as the previous access produces no memory ready and ends in a timeout with `err`. This is documented behaviour.

## Timing
- **Reset values:** state IDLE, `mem_addr` = 0, `mem_wdata` = 0, `mem_we` = 0, all `ack`/`err` = 0, `rdata` = 0, pointer favours port 0, counter = 0.
- **Reset mid-transaction:** the transaction is abandoned with no `ack`, and the ISSUE write strobe is dropped if in flight.
- **Cycle schedule:** `req` seen in IDLE at cycle t; ISSUE at t+1; WAIT from t+2; ready sampled at cycle r; DONE/`ack` at r+1; IDLE at r+2.
- A ready pulse in ISSUE is ignored (only WAIT samples ready).
- **Minimum transaction:** 4 cycles, when ready arrives at t+2.
- **Timeout:** `ack` + `err` at t+3+TIMEOUT.
- **Back-to-back:** the next grant's ISSUE comes no earlier than 2 cycles after `ack`.

## Structure
- Package `ddr_arb_pkg`:
  - state enum
  - `ADDR_W` / `DATA_W` defaults
  - `TIMEOUT` default and counter width constant (8 bits)
- Sub-module `rr_arb2`: two-input round-robin picker. It takes `req[1:0]`, `last`, and an `update` strobe, and outputs a one-hot `gnt`. It is purely registered in its pointer only.
- The top level holds the FSM, request latch, timeout counter and per-port rdata registers.

## Test plan
- Single write, port 0, addr 0x00100, data 0xA5; memory asserts `mem_rdy_we` 8 cycles after ISSUE. Required: `mem_we` high for exactly 1 cycle, `ack_0` 1 cycle later, `err_0` = 0.
- Read port 1, addr 0x00100, after the above write. Required: `rdata_1` = 0xA5 with `ack_1`, and `mem_addr` held stable from ISSUE to DONE.
- Both ports request in the same cycle after reset. Required: port 0 served first, then port 1. With both held high, the grant sequence alternates 0,1,0,1.
- Sequential reads 0x00200, 0x00201 from port 0. Required: the second read completes on the fast `mem_rdy_re` path, and `ack` appears within 4 cycles of `req`.
- Read to the same address twice with no ready from memory, `TIMEOUT` = 32. Required: `ack_0` and `err_0` at t+35, and `rdata_0` unchanged.
- `rst` asserted during WAIT. Required: next cycle state IDLE, all outputs at reset values, no `ack`; a request after `rst` deasserts is then served normally.
